// File: rtl/servo_gen_if.sv
// Primary-bus connection for the servo generator: address, strobes, write
// data and the OR-able read-data return path.
interface servo_gen_if;
    logic [23:0] Addr;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataWr;
    logic [15:0] SecDataRd;

    modport master (output Addr, Rd, Wr, DataWr, input SecDataRd);
    modport slave  (input Addr, Rd, Wr, DataWr, output SecDataRd);
endinterface

// File: rtl/servo_gen.sv
// Four-channel servo pulse generator. A prescaler produces a tick every
// PRESCALE clocks; a frame counter counts FRAME ticks. Each channel drives its
// output high while enabled and the frame position is below its active width.
// Widths are written into shadows and only take effect at the next frame start.
module servo_gen #(
    parameter logic [23:0] BASE_ADDR = 24'h000040,
    parameter int          PRESCALE  = 50,
    parameter int          FRAME     = 20000
) (
    input  logic         Clk,
    input  logic         Reset,
    servo_gen_if.slave   bus,
    output logic [3:0]   Servo
);
    localparam int              NUM_CH     = 4;
    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [15:0]     FRAME_LAST = 16'(FRAME - 1);

    logic                         sel;
    logic [2:0]                   idx;
    logic                         wr_en;
    logic                         tick;
    logic                         fstart;
    logic [PW-1:0]                pre_q, pre_d;
    logic [15:0]                  fcnt_q, fcnt_d;
    logic [15:0]                  framecnt_q, framecnt_d;
    logic [NUM_CH-1:0]            ctrl_q, ctrl_d;
    logic [NUM_CH-1:0][15:0]      shadow_q, shadow_d;
    logic [NUM_CH-1:0][15:0]      act_q, act_d;
    logic [NUM_CH-1:0]            servo_q, servo_d;
    logic [15:0]                  rd_val;

    assign sel   = (bus.Addr[23:4] == BASE_ADDR[23:4]);
    assign idx   = bus.Addr[3:1];
    assign wr_en = bus.Wr & sel;

    // Prescaler, frame position and frame-start counter
    always_comb begin
        tick       = (pre_q == PRE_LAST);
        pre_d      = tick ? '0 : pre_q + 1'b1;
        fstart     = tick && (fcnt_q == FRAME_LAST);
        fcnt_d     = fcnt_q;
        if (tick) fcnt_d = fstart ? 16'd0 : fcnt_q + 16'd1;
        framecnt_d = fstart ? framecnt_q + 16'd1 : framecnt_q;
    end

    // Register writes; FRAMECNT and reserved indices ignore writes
    always_comb begin
        ctrl_d   = ctrl_q;
        shadow_d = shadow_q;
        if (wr_en) begin
            case (idx)
                3'd0:                   ctrl_d = bus.DataWr[NUM_CH-1:0];
                3'd1, 3'd2, 3'd3, 3'd4: shadow_d[2'(idx - 3'd1)] = bus.DataWr;
                default: ;
            endcase
        end
    end

    // Per-channel: the active width latches the pre-write shadow at frame
    // start (so a coinciding write waits a frame), clamped to keep one low
    // tick. The output is computed from next-state values so an enable
    // change shows on the very next edge.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign act_d[g]   = fstart ? ((shadow_q[g] > FRAME_LAST) ? FRAME_LAST : shadow_q[g])
                                   : act_q[g];
        assign servo_d[g] = ctrl_d[g] & (fcnt_d < act_d[g]);
    end

    // Combinational readback, zero when not selected so secondaries can be ORed
    always_comb begin
        rd_val = 16'h0000;
        case (idx)
            3'd0:                   rd_val = {{(16-NUM_CH){1'b0}}, ctrl_q};
            3'd1, 3'd2, 3'd3, 3'd4: rd_val = shadow_q[2'(idx - 3'd1)];
            3'd5:                   rd_val = framecnt_q;
            default:                rd_val = 16'h0000;
        endcase
        bus.SecDataRd = (bus.Rd && sel) ? rd_val : 16'h0000;
    end

    // State registers; reset wins over a simultaneous write
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pre_q      <= '0;
            fcnt_q     <= '0;
            framecnt_q <= '0;
            ctrl_q     <= '0;
            shadow_q   <= '0;
            act_q      <= '0;
            servo_q    <= '0;
        end else begin
            pre_q      <= pre_d;
            fcnt_q     <= fcnt_d;
            framecnt_q <= framecnt_d;
            ctrl_q     <= ctrl_d;
            shadow_q   <= shadow_d;
            act_q      <= act_d;
            servo_q    <= servo_d;
        end
    end

    assign Servo = servo_q;
endmodule

// File: tb/tb_servo_gen.sv
// Randomized and directed bench for servo_gen with a timeline-based reference
// model; expected Servo/read values go into queues checked by a monitor.
module tb_servo_gen;
    localparam int P = 2;
    localparam int F = 100;
    localparam logic [19:0] BLK = 20'h00004;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [3:0] Servo;

    servo_gen_if bus();

    servo_gen #(.BASE_ADDR(24'h000040), .PRESCALE(P), .FRAME(F)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus), .Servo(Servo)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0]  exp_servo_q[$];
    logic [15:0] exp_rd_q[$];
    logic [3:0]  mon_e;

    // reference model: cycles since reset release, registers as plain ints
    int         m_c;
    logic [3:0] m_ctrl;
    int         m_sh[4];
    int         m_act[4];
    int         m_fc;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [23:0] a);
        if (a[23:4] != BLK) return 16'h0000;
        case (a[3:1])
            3'd0:                   return {12'h000, m_ctrl};
            3'd1, 3'd2, 3'd3, 3'd4: return 16'(m_sh[int'(a[3:1]) - 1]);
            3'd5:                   return 16'(m_fc);
            default:                return 16'h0000;
        endcase
    endfunction

    function automatic logic [3:0] m_servo();
        int pos;
        logic [3:0] r;
        pos = (m_c / P) % F;
        for (int n = 0; n < 4; n++) r[n] = m_ctrl[n] && (pos < m_act[n]);
        return r;
    endfunction

    task automatic model_edge();
        if (Reset) begin
            m_c = 0; m_ctrl = 4'h0; m_fc = 0;
            for (int n = 0; n < 4; n++) begin m_sh[n] = 0; m_act[n] = 0; end
        end else begin
            m_c++;
            if (m_c % (P * F) == 0) begin
                for (int n = 0; n < 4; n++) m_act[n] = (m_sh[n] >= F) ? F - 1 : m_sh[n];
                m_fc = (m_fc + 1) % 65536;
            end
            if (bus.Wr && bus.Addr[23:4] == BLK) begin
                case (bus.Addr[3:1])
                    3'd0:                   m_ctrl = bus.DataWr[3:0];
                    3'd1, 3'd2, 3'd3, 3'd4: m_sh[int'(bus.Addr[3:1]) - 1] = int'(bus.DataWr);
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        exp_servo_q.push_back(m_servo());
        #1;
        bus.Rd = 1'b0;
        bus.Wr = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] a, input logic [15:0] d);
        bus.Addr = a; bus.DataWr = d; bus.Wr = 1'b1;
        step();
    endtask

    task automatic do_read(input logic [23:0] a);
        bus.Addr = a; bus.Rd = 1'b1;
        exp_rd_q.push_back(m_read(a));
        step();
    endtask

    task automatic do_read_chk(input string name, input logic [23:0] a, input logic [15:0] e);
        bus.Addr = a; bus.Rd = 1'b1;
        exp_rd_q.push_back(m_read(a));
        #1;
        chk(name, bus.SecDataRd, e);
        step();
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) step();
        Reset = 1'b0;
    endtask

    task automatic wait_level(input int ch, input logic lvl, input int budget, input string name);
        int k = 0;
        while (Servo[ch] !== lvl && k < budget) begin step(); k++; end
        chk(name, {15'h0, Servo[ch]}, {15'h0, lvl});
    endtask

    task automatic meas(input int ch, input logic lvl, output int n);
        n = 0;
        while (Servo[ch] === lvl && n < 1000) begin step(); n++; end
    endtask

    // monitor: compare DUT against queued expectations away from the rising edge
    always @(negedge Clk) begin
        if (exp_servo_q.size() > 0) begin
            mon_e = exp_servo_q.pop_front();
            chk("servo", {12'h000, Servo}, {12'h000, mon_e});
        end
        if (bus.Rd === 1'b1) begin
            if (exp_rd_q.size() == 0) chk("rd_unexpected", 16'h0001, 16'h0000);
            else chk("rd_data", bus.SecDataRd, exp_rd_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int r;
        logic [23:0] a;
        bus.Addr = '0; bus.Rd = 1'b0; bus.Wr = 1'b0; bus.DataWr = '0;
        Reset = 1'b1;

        // reset state
        do_reset(3);
        chk("reset_servo", {12'h000, Servo}, 16'h0000);
        do_read_chk("rst_ctrl", 24'h000040, 16'h0000);
        do_read_chk("rst_w0", 24'h000042, 16'h0000);
        do_read_chk("rst_fcnt", 24'h00004A, 16'h0000);

        // width 30 on channel 0: 60 high, 140 low
        do_write(24'h000042, 16'd30);
        do_write(24'h000040, 16'd1);
        wait_level(0, 1'b1, 500, "ch0_rise");
        meas(0, 1'b1, n); chk("w30_hi", 16'(n), 16'd60);
        meas(0, 1'b0, n); chk("w30_lo", 16'(n), 16'd140);
        meas(0, 1'b1, n); chk("w30_hi2", 16'(n), 16'd60);

        // mid-frame width change only affects the following frame
        wait_level(0, 1'b1, 500, "ch0_rise2");
        repeat (10) step();
        do_write(24'h000042, 16'd40);
        meas(0, 1'b1, n); chk("mid_hi_cur", 16'(n + 11), 16'd60);
        meas(0, 1'b0, n); chk("mid_lo", 16'(n), 16'd140);
        meas(0, 1'b1, n); chk("mid_hi_next", 16'(n), 16'd80);

        // over-range width clamps to FRAME-1
        do_write(24'h000048, 16'd500);
        do_write(24'h000040, 16'd8);
        wait_level(3, 1'b1, 600, "ch3_rise");
        meas(3, 1'b1, n); chk("clamp_hi", 16'(n), 16'd198);
        meas(3, 1'b0, n); chk("clamp_lo", 16'(n), 16'd2);
        meas(3, 1'b1, n); chk("clamp_hi2", 16'(n), 16'd198);

        // clearing the enable mid-pulse drops the output on the next edge
        do_write(24'h000040, 16'd1);
        wait_level(0, 1'b1, 600, "ch0_rise3");
        repeat (5) step();
        chk("pre_clear", {15'h0, Servo[0]}, 16'h0001);
        do_write(24'h000040, 16'd0);
        chk("ctrl_clear", {15'h0, Servo[0]}, 16'h0000);
        do_read_chk("unsel_rd", 24'h000080, 16'h0000);
        do_read_chk("ctrl_hi_zero", 24'h000040, 16'h0000);

        // frame counter and reset mid-pulse
        do_reset(3);
        repeat (610) step();
        do_read_chk("framecnt3", 24'h00004A, 16'd3);
        do_write(24'h000042, 16'd30);
        do_write(24'h000040, 16'd1);
        wait_level(0, 1'b1, 500, "ch0_rise4");
        repeat (5) step();
        Reset = 1'b1;
        step();
        chk("rst_mid_servo", {12'h000, Servo}, 16'h0000);
        do_read_chk("rst_mid_fcnt", 24'h00004A, 16'h0000);
        Reset = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 999) == 0) begin
                do_reset(2);
            end else if (r == 0) begin
                k = $urandom_range(0, 7);
                a = {BLK, 3'(k), 1'($urandom_range(0, 1))};
                if ($urandom_range(0, 3) == 0) do_write(a, 16'($urandom));
                else do_write(a, 16'($urandom_range(0, 130)));
            end else if (r <= 2) begin
                if ($urandom_range(0, 4) == 0) a = 24'($urandom);
                else a = {BLK, 4'($urandom_range(0, 15))};
                do_read(a);
            end else begin
                step();
            end
        end

        @(negedge Clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
